// File: rtl/ain_cmd_arbiter.sv
// ain_cmd_arbiter
//   Round-robin arbiter that shares the 2-bit gesture channel (ain) of the
//   yout Moore decoder among NREQ command sources.
//
//   Each granted command goes through these states:
//     IDLE  -> DRIVE : the code is held on ain for CODE_CYCLES cycles.
//     DRIVE -> FLUSH : ain is 00 for IDLE_CYCLES cycles, so the decoder
//                      commits the action and returns to hold.
//     FLUSH -> ACK   : a 1-cycle ack goes to the granted requester.
//   A granted code of 00 is invalid. It goes straight from IDLE to ACK with
//   err set, and ain is never driven.
//
// Ports
//   clk       in   rising-edge system clock
//   reset     in   asynchronous, active-high reset
//   req       in   [NREQ]      request per requester, held until its ack
//   cmd       in   [2*NREQ]    cmd[2i+1:2i] = code of requester i
//   ain       out  [2]         registered drive to the decoder ain input
//   ack       out  [NREQ]      1-cycle completion pulse, one-hot
//   err       out  1           pulses with ack when the granted code was 00
//   busy      out  1           high in every state except IDLE
//   grant_id  out  [clog2 NREQ] current or last granted requester
module ain_cmd_arbiter #(
  parameter int NREQ        = 4,
  parameter int CODE_CYCLES = 1,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [2*NREQ-1:0]         cmd,
  output logic [1:0]                ain,
  output logic [NREQ-1:0]           ack,
  output logic                      err,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int GW   = $clog2(NREQ);
  localparam int MAXC = (CODE_CYCLES > IDLE_CYCLES) ? CODE_CYCLES : IDLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    code_reg;
  logic [GW-1:0] ptr_reg;

  // Split the flat command bus into one 2-bit code per requester.
  logic [1:0] cmd_arr [NREQ];
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cmd
      assign cmd_arr[gi] = cmd[2*gi +: 2];
    end
  endgenerate

  // Round-robin pick. The lowest set request at or above the pointer wins.
  // If there is none, the lowest set request below the pointer wins, which
  // wraps the search around modulo NREQ.
  logic          hi_valid, lo_valid, pick_valid;
  logic [GW-1:0] hi_idx, lo_idx, pick_idx;
  logic [1:0]    pick_code;

  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (GW'(i) >= ptr_reg) begin
          hi_valid = 1'b1;
          hi_idx   = GW'(i);
        end else begin
          lo_valid = 1'b1;
          lo_idx   = GW'(i);
        end
      end
    end
    pick_valid = hi_valid | lo_valid;
    pick_idx   = hi_valid ? hi_idx : lo_idx;
    pick_code  = cmd_arr[pick_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      code_reg  <= 2'b00;
      ptr_reg   <= '0;
      ain       <= 2'b00;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      // ack and err are single-cycle pulses unless a branch below sets them.
      ack <= '0;
      err <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ain <= 2'b00;
          if (pick_valid) begin
            grant_id <= pick_idx;
            code_reg <= pick_code;
            busy     <= 1'b1;
            if (pick_code != 2'b00) begin
              state_reg <= ST_DRIVE;
              ain       <= pick_code;
              cnt_reg   <= CW'(CODE_CYCLES - 1);
            end else begin
              // Invalid code: ain is never driven. Finish at once with err.
              state_reg <= ST_ACK;
              ack       <= ONE_HOT0 << pick_idx;
              err       <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_FLUSH;
            ain       <= 2'b00;
            cnt_reg   <= CW'(IDLE_CYCLES - 1);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_ACK;
            ack       <= ONE_HOT0 << grant_id;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          // ACK: advance the pointer past the requester just served.
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          ain       <= 2'b00;
          ptr_reg   <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ain_cmd_arbiter.sv
// Testbench for ain_cmd_arbiter.
//
// Two instances are used:
//   dut   : NREQ=4, CODE_CYCLES=1, IDLE_CYCLES=2 (default parameters)
//   dut_b : NREQ=4, CODE_CYCLES=3, IDLE_CYCLES=4 (long-timing parameters)
//
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge. "Cycle k" of a transaction is the k-th falling edge after the request
// was applied.
module tb_ain_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req_b;
  logic [7:0] cmd, cmd_b;
  logic [1:0] ain, ain_b;
  logic [3:0] ack, ack_b;
  logic       err, err_b;
  logic       busy, busy_b;
  logic [1:0] grant_id, grant_b;

  always #5 clk = ~clk;

  ain_cmd_arbiter #(.NREQ(4), .CODE_CYCLES(1), .IDLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd(cmd), .ain(ain), .ack(ack),
    .err(err), .busy(busy), .grant_id(grant_id)
  );

  ain_cmd_arbiter #(.NREQ(4), .CODE_CYCLES(3), .IDLE_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .cmd(cmd_b), .ain(ain_b), .ack(ack_b),
    .err(err_b), .busy(busy_b), .grant_id(grant_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [7:0] cmd;
    logic [1:0] code;      // expected ain in the drive cycle; 00 means invalid
    logic [3:0] exp_ack;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t       vecs [6];
  logic [1:0] cont_codes [4];
  logic [1:0] fair_exp [4];
  logic [3:0] exp_oh;
  int         waited;
  int         t;
  int         ph;

  initial begin
    // Expected values are computed by hand. The pointer starts at 0 after
    // reset and moves to grant+1 after each transaction.
    vecs[0] = '{req: 4'b0100, cmd: 8'b00_11_00_00, code: 2'b11, exp_ack: 4'b0100, exp_grant: 2'd2}; // ptr -> 3
    vecs[1] = '{req: 4'b0010, cmd: 8'b11_11_00_11, code: 2'b00, exp_ack: 4'b0010, exp_grant: 2'd1}; // ptr -> 2
    vecs[2] = '{req: 4'b1001, cmd: 8'b01_00_00_10, code: 2'b01, exp_ack: 4'b1000, exp_grant: 2'd3}; // ptr -> 0
    vecs[3] = '{req: 4'b1001, cmd: 8'b01_00_00_10, code: 2'b10, exp_ack: 4'b0001, exp_grant: 2'd0}; // ptr -> 1
    vecs[4] = '{req: 4'b0001, cmd: 8'b00_00_00_11, code: 2'b11, exp_ack: 4'b0001, exp_grant: 2'd0}; // wraps; ptr -> 1
    vecs[5] = '{req: 4'b0100, cmd: 8'b00_10_00_00, code: 2'b10, exp_ack: 4'b0100, exp_grant: 2'd2}; // ptr -> 3
    cont_codes[0] = 2'b11;
    cont_codes[1] = 2'b01;
    cont_codes[2] = 2'b10;
    cont_codes[3] = 2'b11;
    fair_exp[0] = 2'd0;
    fair_exp[1] = 2'd1;
    fair_exp[2] = 2'd0;
    fair_exp[3] = 2'd1;

    reset = 1'b1;
    req   = '0;
    cmd   = '0;
    req_b = '0;
    cmd_b = '0;

    // Reset state
    nclk();
    check("rst_ain", ain, 2'b00);
    check("rst_ack", ack, 4'b0000);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_ain_b", ain_b, 2'b00);
    reset = 1'b0;
    nclk();

    // Single transactions from the vector table
    for (int v = 0; v < 6; v++) begin
      req = vecs[v].req;
      cmd = vecs[v].cmd;
      if (vecs[v].code != 2'b00) begin
        nclk();
        check("vec_ain_c1", ain, vecs[v].code);
        check("vec_busy_c1", busy, 1'b1);
        check("vec_ack_c1", ack, 4'b0000);
        for (int c = 2; c <= 3; c++) begin
          nclk();
          check("vec_ain_flush", ain, 2'b00);
          check("vec_ack_flush", ack, 4'b0000);
        end
        nclk();
        check("vec_ack", ack, vecs[v].exp_ack);
        check("vec_err", err, 1'b0);
        check("vec_grant", grant_id, vecs[v].exp_grant);
        check("vec_ain_ack", ain, 2'b00);
      end else begin
        nclk();
        check("inv_ack", ack, vecs[v].exp_ack);
        check("inv_err", err, 1'b1);
        check("inv_ain", ain, 2'b00);
        check("inv_busy", busy, 1'b1);
        check("inv_grant", grant_id, vecs[v].exp_grant);
      end
      nclk();
      req = '0;
      check("vec_ack_after", ack, 4'b0000);
      check("vec_err_after", err, 1'b0);
      check("vec_busy_after", busy, 1'b0);
    end

    // Reset in the middle of a set transaction (the pointer is 3 here)
    req = 4'b0100;
    cmd = 8'b00_11_00_00;
    nclk();
    check("mid_ain_c1", ain, 2'b11);
    check("mid_grant_c1", grant_id, 2'd2);
    nclk();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ain", ain, 2'b00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ack", ack, 4'b0000);
    check("mid_rst_grant", grant_id, 2'd0);
    req = 4'b1111;
    cmd = 8'b11_10_01_11;
    nclk();
    reset = 1'b0;
    nclk();
    check("post_rst_ain", ain, 2'b11);
    check("post_rst_grant", grant_id, 2'd0);
    nclk();
    nclk();
    nclk();
    check("post_rst_ack", ack, 4'b0001);
    nclk();
    req = '0;

    // Contention from reset: grants must go 0,1,2,3 with acks at cycles 4, 9, 14, 19
    reset = 1'b1;
    nclk();
    req   = 4'b1111;
    cmd   = 8'b11_10_01_11;
    reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      nclk();
      t  = (c - 1) / 5;
      ph = (c - 1) % 5;
      exp_oh = '0;
      if (ph == 3) exp_oh[t] = 1'b1;
      check($sformatf("cont_ain_c%0d", c), ain, (ph == 0) ? cont_codes[t] : 2'b00);
      check($sformatf("cont_ack_c%0d", c), ack, exp_oh);
    end
    req = '0;

    // Fairness: req[0] is held permanently. req[1] drops for one cycle after each of its acks.
    nclk();
    req = 4'b0011;
    cmd = 8'b00_00_01_11;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      do begin
        nclk();
        waited++;
      end while (ack == 4'b0000 && waited < 20);
      exp_oh = '0;
      exp_oh[fair_exp[g]] = 1'b1;
      check($sformatf("fair_ack_%0d", g), ack, exp_oh);
      if (ack[1]) begin
        nclk();
        req[1] = 1'b0;
        nclk();
        req[1] = 1'b1;
      end
    end
    req = '0;
    nclk();
    nclk();

    // Long timing: 3 cycles of code, 4 cycles of 00, ack at cycle 8. A cmd change is ignored.
    req_b = 4'b0001;
    cmd_b = 8'h01;
    for (int c = 1; c <= 3; c++) begin
      nclk();
      check($sformatf("long_ain_c%0d", c), ain_b, 2'b01);
      check($sformatf("long_ack_c%0d", c), ack_b, 4'b0000);
      cmd_b = 8'h03;
    end
    for (int c = 4; c <= 7; c++) begin
      nclk();
      check($sformatf("long_ain_c%0d", c), ain_b, 2'b00);
      check($sformatf("long_ack_c%0d", c), ack_b, 4'b0000);
    end
    nclk();
    check("long_ack_c8", ack_b, 4'b0001);
    check("long_err_c8", err_b, 1'b0);
    check("long_grant_c8", grant_b, 2'd0);
    check("long_busy_c8", busy_b, 1'b1);
    nclk();
    req_b = '0;
    check("long_busy_c9", busy_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
